scene_param_loader: RTL

Parametrised successor to the top-level parameter capture path. It assembles a framed byte stream into a bank of `NUM_REGS` × `REG_W` scene registers (vertices, normals, light, VP matrix, render mode). Writes land in a shadow bank, are checksum-validated, and are published to the active bank only on a frame boundary, so the vertex shader and raster always see a coherent set. It sits between the UART byte receiver and the vertex-shader/raster stages and replaces the fixed 60-byte index decode.

---
 rtl/scene_param_pkg.sv | 23 ++
 rtl/param_frame_parser.sv | 71 +++++++
 rtl/scene_param_loader.sv | 80 ++++++++
 3 files changed

// File: rtl/scene_param_pkg.sv
// scene_param_pkg: shared sync byte, parser states and scene register map
package scene_param_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM} state_t;
  localparam int V0X = 0;
  localparam int V0Y = 1;
  localparam int V0Z = 2;
  localparam int V1X = 3;
  localparam int V1Y = 4;
  localparam int V1Z = 5;
  localparam int V2X = 6;
  localparam int V2Y = 7;
  localparam int V2Z = 8;
  localparam int NX = 9;
  localparam int NY = 10;
  localparam int NZ = 11;
  localparam int LX = 12;
  localparam int LY = 13;
  localparam int LZ = 14;
  localparam int VP00 = 15;
  localparam int VP33 = 30;
  localparam int RENDER_MODE = 31;
endpackage

// File: rtl/param_frame_parser.sv
// param_frame_parser: decodes framed packets into byte writes, commit and abort strobes
module param_frame_parser
  import scene_param_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
  input  logic [7:0] byte_in,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       commit,
  output logic       abort,
  output logic       err_csum,
  output logic       err_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_nx;
  logic [7:0] csum, rem, baddr;
  logic [TW-1:0] tcnt;
  logic timeout;
  assign timeout = state != IDLE && !accept && tcnt == TW'(TIMEOUT_CYC - 1);
  assign wr_en = accept && state == DATA;
  assign wr_addr = baddr;
  assign wr_data = byte_in;
  assign err_timeout = timeout;
  assign abort = err_csum | timeout;
  // next state plus commit/checksum-error decode on each accepted byte
  always_comb begin
    state_nx = state;
    commit = 1'b0;
    err_csum = 1'b0;
    if (timeout) state_nx = IDLE;
    else if (accept)
      case (state)
        IDLE: state_nx = byte_in == SYNC_BYTE ? ADDR : IDLE;
        ADDR: state_nx = LEN;
        LEN: begin
          state_nx = byte_in == 8'd0 ? IDLE : DATA;
          err_csum = byte_in == 8'd0;
        end
        DATA: state_nx = rem == 8'd1 ? CSUM : DATA;
        CSUM: begin
          state_nx = IDLE;
          commit = byte_in == csum;
          err_csum = byte_in != csum;
        end
        default: state_nx = IDLE;
      endcase
  end
  // state, running xor, remaining length, byte address and idle timer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      csum <= '0;
      rem <= '0;
      baddr <= '0;
      tcnt <= '0;
    end else begin
      state <= state_nx;
      tcnt <= (state == IDLE || accept || timeout) ? '0 : tcnt + 1'b1;
      if (accept) begin
        csum <= state == ADDR ? byte_in : csum ^ byte_in;
        rem <= state == LEN ? byte_in : rem - 1'b1;
        baddr <= state == ADDR ? byte_in : state == DATA ? baddr + 1'b1 : baddr;
      end
    end
  end
endmodule

// File: rtl/scene_param_loader.sv
// scene_param_loader: shadow/active scene register banks loaded from a framed byte stream
module scene_param_loader
  import scene_param_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  input  logic                      frame_start,
  output logic [NUM_REGS*REG_W-1:0] active_flat,
  output logic                      cfg_updated,
  output logic                      pending,
  output logic                      err_csum,
  output logic                      err_timeout,
  output logic [7:0]                err_count
);
  localparam int BPR = REG_W / 8;
  localparam int NBYTES = NUM_REGS * BPR;
  localparam int AW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  logic [7:0] shadow [NBYTES];
  logic [7:0] active [NBYTES];
  logic accept, wr_en, commit, abort, p_err_csum, p_err_timeout, in_range, swap;
  logic [7:0] wr_addr, wr_data;
  assign in_ready = !pending;
  assign accept = in_valid && in_ready;
  assign in_range = {1'b0, wr_addr} < 9'(NBYTES);
  assign swap = frame_start && pending;
  param_frame_parser #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_parser (
    .clk(clk),
    .reset(reset),
    .accept(accept),
    .byte_in(in_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
    .abort(abort),
    .err_csum(p_err_csum),
    .err_timeout(p_err_timeout)
  );
  for (genvar i = 0; i < NBYTES; i++) begin : g_flat
    assign active_flat[i*8 +: 8] = active[i];
  end
  // shadow writes/revert and the frame-boundary publish into the active bank
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBYTES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending <= 1'b0;
      cfg_updated <= 1'b0;
    end else begin
      cfg_updated <= swap;
      if (swap) begin
        pending <= 1'b0;
        for (int i = 0; i < NBYTES; i++) active[i] <= shadow[i];
      end else if (commit) pending <= 1'b1;
      if (abort) for (int i = 0; i < NBYTES; i++) shadow[i] <= active[i];
      else if (wr_en && in_range) shadow[wr_addr[AW-1:0]] <= wr_data;
    end
  end
  // error pulses and saturating error counter, one step per erroring cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      err_csum <= 1'b0;
      err_timeout <= 1'b0;
      err_count <= '0;
    end else begin
      err_csum <= p_err_csum;
      err_timeout <= p_err_timeout;
      if ((p_err_csum || p_err_timeout) && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end
endmodule
